// File: rtl/stump_pkg.sv
// Shared definitions for the Stump control unit.
// Contents: opcode constants, FSM state encodings, branch condition codes,
// operand-B and write-back source encodings, and flag bit positions.
package stump_pkg;

   // Opcodes, ir[15:13]
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_SBC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_LDST = 3'b110;
   localparam logic [2:0] OP_BCC = 3'b111;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_EXECUTE = 2'b01,
      ST_MEMORY  = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

   // Branch conditions, ir[11:8]
   localparam logic [3:0] COND_AL = 4'h0;
   localparam logic [3:0] COND_NV = 4'h1;
   localparam logic [3:0] COND_HI = 4'h2;
   localparam logic [3:0] COND_LS = 4'h3;
   localparam logic [3:0] COND_CC = 4'h4;
   localparam logic [3:0] COND_CS = 4'h5;
   localparam logic [3:0] COND_NE = 4'h6;
   localparam logic [3:0] COND_EQ = 4'h7;
   localparam logic [3:0] COND_VC = 4'h8;
   localparam logic [3:0] COND_VS = 4'h9;
   localparam logic [3:0] COND_PL = 4'hA;
   localparam logic [3:0] COND_MI = 4'hB;
   localparam logic [3:0] COND_GE = 4'hC;
   localparam logic [3:0] COND_LT = 4'hD;
   localparam logic [3:0] COND_GT = 4'hE;
   localparam logic [3:0] COND_LE = 4'hF;

   // Operand-B source
   localparam logic [1:0] OPB_REG   = 2'b00;
   localparam logic [1:0] OPB_IMM5  = 2'b01;
   localparam logic [1:0] OPB_IMM8  = 2'b10;
   localparam logic [1:0] OPB_ONE   = 2'b11;

   // Write-back source
   localparam logic WB_ALU = 1'b0;
   localparam logic WB_MEM = 1'b1;

   // Flag bit positions within {N,Z,V,C}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/stump_control_if.sv
// Bus between the Stump control unit and its datapath.
// slave  : control-unit side (receives mem_data/alu_flags, drives controls)
// master : datapath side (drives mem_data/alu_flags, receives controls)
interface stump_control_if;
   logic [15:0] mem_data;
   logic [3:0]  alu_flags;
   logic [1:0]  state;
   logic [15:0] ir;
   logic [3:0]  cc;
   logic [2:0]  func;
   logic [1:0]  opb_sel;
   logic [1:0]  shift_op;
   logic [2:0]  srcA;
   logic [2:0]  srcB;
   logic [2:0]  dest;
   logic        reg_write;
   logic        wb_sel;
   logic        addr_en;
   logic        addr_sel;
   logic        mem_ren;
   logic        mem_wen;

   modport slave (
      input  mem_data, alu_flags,
      output state, ir, cc, func, opb_sel, shift_op, srcA, srcB, dest,
             reg_write, wb_sel, addr_en, addr_sel, mem_ren, mem_wen
   );

   modport master (
      output mem_data, alu_flags,
      input  state, ir, cc, func, opb_sel, shift_op, srcA, srcB, dest,
             reg_write, wb_sel, addr_en, addr_sel, mem_ren, mem_wen
   );
endinterface

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator (combinational).
// Ports: cond[3:0] branch condition field, cc[3:0] flags {N,Z,V,C},
//        taken = 1 when the condition holds.
module stump_cond_eval
   import stump_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] cc,
   output logic       taken
);
   logic n, z, v, c;
   assign n = cc[FLAG_N];
   assign z = cc[FLAG_Z];
   assign v = cc[FLAG_V];
   assign c = cc[FLAG_C];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b0;
         COND_HI: taken = ~c & ~z;
         COND_LS: taken = c | z;
         COND_CC: taken = ~c;
         COND_CS: taken = c;
         COND_NE: taken = ~z;
         COND_EQ: taken = z;
         COND_VC: taken = ~v;
         COND_VS: taken = v;
         COND_PL: taken = ~n;
         COND_MI: taken = n;
         COND_GE: taken = (n == v);
         COND_LT: taken = (n != v);
         COND_GT: taken = ~z & (n == v);
         COND_LE: taken = z | (n != v);
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer holding IR and CC.
// Ports: clk, rst (synchronous, active high), bus (slave modport):
//   in  mem_data, alu_flags
//   out state, ir, cc, func, opb_sel, shift_op, srcA, srcB, dest,
//       reg_write, wb_sel, addr_en, addr_sel, mem_ren, mem_wen
// All control outputs are decoded combinationally from state and IR.
module stump_control
   import stump_pkg::*;
#(
   parameter logic [2:0] PC_REG = 3'd7
)(
   input  logic           clk,
   input  logic           rst,
   stump_control_if.slave bus
);
   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [3:0]  cc_q, cc_d;
   logic        taken;

   logic [2:0] opcode;
   logic       imm_type;
   logic       s_bit;
   logic       is_alu;
   assign opcode   = ir_q[15:13];
   assign imm_type = ir_q[12];
   assign s_bit    = ir_q[11];
   // Opcodes 000..101 are the plain ALU operations
   assign is_alu   = (opcode <= OP_OR);

   stump_cond_eval u_cond_eval (
      .cond  (ir_q[11:8]),
      .cc    (cc_q),
      .taken (taken)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         cc_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
      end
   end

   // Next-state logic (including IR/CC capture)
   always_comb begin
      state_d = ST_FETCH;
      ir_d    = ir_q;
      cc_d    = cc_q;
      case (state_q)
         ST_FETCH: begin
            ir_d    = bus.mem_data;
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (is_alu && s_bit)
               cc_d = bus.alu_flags;
            state_d = (opcode == OP_LDST) ? ST_MEMORY : ST_FETCH;
         end
         ST_MEMORY: state_d = ST_FETCH;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Output decode
   always_comb begin
      bus.func      = OP_ADD;
      bus.opb_sel   = OPB_REG;
      bus.shift_op  = 2'b00;
      bus.srcA      = ir_q[7:5];
      bus.srcB      = ir_q[4:2];
      bus.dest      = ir_q[10:8];
      bus.reg_write = 1'b0;
      bus.wb_sel    = WB_ALU;
      bus.addr_en   = 1'b0;
      bus.addr_sel  = 1'b0;
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            // Instruction read from PC while the ALU computes PC + 1
            bus.mem_ren   = 1'b1;
            bus.srcA      = PC_REG;
            bus.dest      = PC_REG;
            bus.opb_sel   = OPB_ONE;
            bus.reg_write = 1'b1;
         end
         ST_EXECUTE: begin
            if (opcode == OP_BCC) begin
               bus.srcA      = PC_REG;
               bus.dest      = PC_REG;
               bus.opb_sel   = OPB_IMM8;
               bus.reg_write = taken;
            end else begin
               bus.opb_sel = imm_type ? OPB_IMM5 : OPB_REG;
               if (is_alu) begin
                  bus.func      = opcode;
                  bus.reg_write = 1'b1;
                  if (!imm_type)
                     bus.shift_op = ir_q[1:0];
               end else begin
                  // LD/ST: effective address goes to the address register
                  bus.addr_en = 1'b1;
               end
            end
         end
         ST_MEMORY: begin
            bus.addr_sel = 1'b1;
            if (!s_bit) begin
               bus.mem_ren   = 1'b1;
               bus.reg_write = 1'b1;
               bus.wb_sel    = WB_MEM;
            end else begin
               // Store data is read out through port A
               bus.mem_wen = 1'b1;
               bus.srcA    = ir_q[10:8];
            end
         end
         default: ;
      endcase
   end

   assign bus.state = state_q;
   assign bus.ir    = ir_q;
   assign bus.cc    = cc_q;

endmodule
